// File: rtl/seg7_scan_ctrl.sv
// Scans NUM_DIGITS shadowed BCD digits onto one shared 7-seg decoder with dead time between digits.
// All outputs registered; no backpressure. A digit's code and blanking status are snapshotted when its BLANK dwell starts.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done,
  output logic                    err
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_DASH   = 7'b0000001;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [3:0]              code_q;
  logic                    lz_q;
  logic                    snap_en;
  logic [3:0]              snap_code;
  logic                    snap_lz;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    frame_d;
  logic                    err_d;

  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shadow_q[4*i +: 4] > 4'd9) err_d = 1'b1;
    end
  end

  // Snapshot of the digit about to be scanned: raw code and "all digits from here up are zero".
  always_comb begin
    snap_code = 4'd0;
    snap_lz   = (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) snap_code = shadow_q[4*i +: 4];
      if (IDX_W'(i) >= idx_d && shadow_q[4*i +: 4] != 4'd0) snap_lz = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    an_d    = an_out;
    seg_d   = seg_out;
    frame_d = 1'b0;
    snap_en = 1'b0;
    if (!en) begin
      // Idle dark; keep digit 0 snapshot fresh so a restart shows the current shadow.
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
      an_d    = '1;
      seg_d   = 7'd0;
      snap_en = 1'b1;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d     = DRIVE;
            cnt_d       = '0;
            an_d        = '1;
            an_d[idx_q] = 1'b0;
            if (code_q > 4'd9)        seg_d = SEG_DASH;
            else if (blank_lz && lz_q) seg_d = 7'd0;
            else                       seg_d = seg_in;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            an_d    = '1;
            seg_d   = 7'd0;
            frame_d = (idx_q == LAST_IDX);
            snap_en = 1'b1;
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      code_q     <= 4'd0;
      lz_q       <= 1'b0;
      bcd_out    <= 4'd0;
      seg_out    <= 7'd0;
      an_out     <= '1;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_out    <= seg_d;
      an_out     <= an_d;
      frame_done <= frame_d;
      err        <= err_d;
      if (load) shadow_q <= digits_in;
      if (snap_en) begin
        code_q  <= snap_code;
        lz_q    <= snap_lz;
        bcd_out <= (snap_code > 4'd9) ? 4'd0 : snap_code;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed and random bench for seg7_scan_ctrl with a behavioural BCD decoder on the loop-back.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b1010101;
    endcase
  endfunction

  assign seg_in = dec(bcd_out);

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .blank_lz(blank_lz), .bcd_out(bcd_out), .seg_in(seg_in), .seg_out(seg_out),
    .an_out(an_out), .frame_done(frame_done), .err(err)
  );

  // Expected {an_out, seg_out, frame_done} for cycle c of a frame (5 cycles per digit, DRIVE first).
  // Digits below sw come from word wa, the rest from wb.
  function automatic logic [11:0] exp_cyc(input int c, input logic [15:0] wa,
                                          input logic [15:0] wb, input int sw, input logic blz);
    int          d;
    int          p;
    logic [15:0] w;
    logic [3:0]  code;
    logic        lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    d = c / 5;
    p = c % 5;
    if (p == 4) return {4'hF, 7'd0, (d == 3)};
    w    = (d < sw) ? wa : wb;
    code = w[4*d +: 4];
    lz   = (d != 0);
    for (int j = d; j < 4; j++) if (w[4*j +: 4] != 4'd0) lz = 1'b0;
    an    = 4'hF;
    an[d] = 1'b0;
    if (code > 4'd9)     seg = 7'b0000001;
    else if (blz && lz)  seg = 7'd0;
    else                 seg = dec(code);
    return {an, seg, 1'b0};
  endfunction

  task automatic load_restart(input logic [15:0] w, input logic blz);
    @(negedge clk); en = 1'b0; load = 1'b1; digits_in = w; blank_lz = blz;
    @(negedge clk); load = 1'b0;
    @(negedge clk); en = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_out, seg_out, frame_done, bcd_out, err} !== {4'hF, 7'd0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got an=%b seg=%b fd=%b bcd=%h err=%b, want an=1111 seg=0 fd=0 bcd=0 err=0",
               an_out, seg_out, frame_done, bcd_out, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({an_out, seg_out, frame_done} !== {4'hF, 7'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: got an=%b seg=%b fd=%b, want an=1111 seg=0 fd=0", an_out, seg_out, frame_done);
    end
  endtask

  task automatic test_scan;
    logic [11:0] e;
    load_restart(16'h1234, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_cyc(c % 20, 16'h1234, 16'h1234, 4, 1'b0);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== e) begin
        n_fail++;
        $display("FAIL scan c=%0d: got an=%b seg=%b fd=%b, want %b", c, an_out, seg_out, frame_done, e);
      end
    end
  endtask

  task automatic test_lead_blank;
    logic [11:0] e;
    logic [15:0] words [2];
    words[0] = 16'h0007;
    words[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      load_restart(words[k], 1'b1);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        e = exp_cyc(c, words[k], words[k], 4, 1'b1);
        n_checks++;
        if ({an_out, seg_out, frame_done} !== e) begin
          n_fail++;
          $display("FAIL lead_blank w=%h c=%0d: got an=%b seg=%b fd=%b, want %b",
                   words[k], c, an_out, seg_out, frame_done, e);
        end
      end
    end
  endtask

  task automatic test_invalid;
    logic [11:0] e;
    @(negedge clk); load = 1'b1; digits_in = 16'h0A05;
    @(negedge clk); load = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_lag: got err=%b, want 0 on the load edge", err);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got err=%b, want 1", err);
    end
    load_restart(16'h0A05, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = exp_cyc(c, 16'h0A05, 16'h0A05, 4, 1'b1);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== e) begin
        n_fail++;
        $display("FAIL invalid c=%0d: got an=%b seg=%b fd=%b, want %b", c, an_out, seg_out, frame_done, e);
      end
      n_checks++;
      if (bcd_out > 4'd9) begin
        n_fail++;
        $display("FAIL bcd_range c=%0d: got bcd=%h, want <=9", c, bcd_out);
      end
    end
    @(negedge clk); load = 1'b1; digits_in = 16'h0005;
    @(negedge clk); load = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_hold: got err=%b, want 1 on the load edge", err);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b, want 0", err);
    end
  endtask

  task automatic test_mid_dwell_load;
    logic [11:0] e;
    load_restart(16'h1234, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = exp_cyc(c, 16'h1234, 16'h9999, 2, 1'b0);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== e) begin
        n_fail++;
        $display("FAIL mid_load c=%0d: got an=%b seg=%b fd=%b, want %b", c, an_out, seg_out, frame_done, e);
      end
      if (c == 6) begin load = 1'b1; digits_in = 16'h9999; end
      if (c == 7) load = 1'b0;
    end
  endtask

  task automatic test_en_and_reset;
    logic [11:0] e;
    load_restart(16'hF234, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      e = exp_cyc(c, 16'hF234, 16'hF234, 4, 1'b0);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== e) begin
        n_fail++;
        $display("FAIL pre_drop c=%0d: got an=%b seg=%b fd=%b, want %b", c, an_out, seg_out, frame_done, e);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== {4'hF, 7'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL en_low k=%0d: got an=%b seg=%b fd=%b, want an=1111 seg=0 fd=0",
                 k, an_out, seg_out, frame_done);
      end
    end
    en = 1'b1;
    n_checks++;
    if (an_out !== 4'hF) begin
      n_fail++;
      $display("FAIL en_restart_blank: got an=%b, want 1111", an_out);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = exp_cyc(c, 16'hF234, 16'hF234, 4, 1'b0);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== e) begin
        n_fail++;
        $display("FAIL en_restart c=%0d: got an=%b seg=%b fd=%b, want %b", c, an_out, seg_out, frame_done, e);
      end
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_pre_reset: got err=%b, want 1", err);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_out, seg_out, frame_done, bcd_out, err} !== {4'hF, 7'd0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_drive: got an=%b seg=%b fd=%b bcd=%h err=%b, want 1111/0/0/0/0",
               an_out, seg_out, frame_done, bcd_out, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = exp_cyc(c, 16'h0000, 16'h0000, 4, 1'b0);
      n_checks++;
      if ({an_out, seg_out, frame_done} !== e) begin
        n_fail++;
        $display("FAIL post_reset c=%0d: got an=%b seg=%b fd=%b, want %b", c, an_out, seg_out, frame_done, e);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] prev_an;
    prev_an = an_out;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      n_checks++;
      if ($countones(~an_out) > 1) begin
        n_fail++;
        $display("FAIL rand_onehot i=%0d: got an=%b, want at most one low bit", i, an_out);
      end
      n_checks++;
      if (prev_an != 4'hF && an_out != 4'hF && an_out != prev_an) begin
        n_fail++;
        $display("FAIL rand_blank_gap i=%0d: got an %b -> %b, want 1111 between digits", i, prev_an, an_out);
      end
      n_checks++;
      if (bcd_out > 4'd9) begin
        n_fail++;
        $display("FAIL rand_bcd i=%0d: got bcd=%h, want <=9", i, bcd_out);
      end
      prev_an   = an_out;
      en        = ($urandom_range(0, 49) != 0);
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom);
      blank_lz  = 1'($urandom_range(0, 1));
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lead_blank();
    test_invalid();
    test_mid_dwell_load();
    test_en_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
